// File: rtl/digit_serial_addsub_pkg.sv
// Shared constants for the digit-serial add/sub block: FSM encoding and opcodes.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Operand/result handshake bundle. The producer/consumer side is master, the
// add/sub block is slave.
interface digit_serial_addsub_if #(
  parameter int N_BITS = 32
);
  logic [N_BITS-1:0] a;
  logic [N_BITS-1:0] b;
  logic              select;
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] out;
  logic              carry_out;
  logic              overflow;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output a, b, select, in_valid, out_ready,
    input  in_ready, out, carry_out, overflow, out_valid
  );

  modport slave (
    input  a, b, select, in_valid, out_ready,
    output in_ready, out, carry_out, overflow, out_valid
  );
endinterface

// File: rtl/digit_serial_addsub_digit.sv
// Combinational DIGIT_BITS-wide adder slice with carry in/out. The sum MSB is
// broken out so the parent can form signed overflow on the top digit.
module addsub_digit #(
  parameter int DIGIT_BITS = 8
) (
  input  logic [DIGIT_BITS-1:0] x,
  input  logic [DIGIT_BITS-1:0] y,
  input  logic                  cin,
  output logic [DIGIT_BITS-1:0] sum,
  output logic                  cout,
  output logic                  sum_msb
);
  logic [DIGIT_BITS:0] w_full;

  assign w_full  = {1'b0, x} + {1'b0, y} + {{DIGIT_BITS{1'b0}}, cin};
  assign sum     = w_full[DIGIT_BITS-1:0];
  assign cout    = w_full[DIGIT_BITS];
  assign sum_msb = w_full[DIGIT_BITS-1];
endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor. One DIGIT_BITS slice per
// cycle, LSB first, carry held in a register between cycles. Subtraction is
// a + ~b + 1: the inversion happens when B is latched and the +1 comes from
// seeding the carry register with the select bit.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int N_BITS     = 32,
  parameter int DIGIT_BITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  digit_serial_addsub_if.slave bus
);
  localparam int N_DIG = N_BITS / DIGIT_BITS;
  localparam int CW    = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  state_t r_state, w_next;

  // Operands and result stored as digit arrays so the counter indexes a slice.
  logic [N_DIG-1:0][DIGIT_BITS-1:0] r_a, r_b, r_out;
  logic [CW-1:0]                    r_cnt;
  logic                             r_cy;
  logic                             r_cout;
  logic                             r_ov;

  logic [DIGIT_BITS-1:0] w_sum;
  logic                  w_cout;
  logic                  w_msb;
  logic                  w_last;
  logic                  w_in_ready;
  logic                  w_out_valid;

  assign w_last = (r_cnt == CW'(N_DIG - 1));

  addsub_digit #(.DIGIT_BITS(DIGIT_BITS)) u_digit (
    .x       (r_a[r_cnt]),
    .y       (r_b[r_cnt]),
    .cin     (r_cy),
    .sum     (w_sum),
    .cout    (w_cout),
    .sum_msb (w_msb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture and per-digit accumulation; results hold outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_out  <= '0;
      r_cnt  <= '0;
      r_cy   <= 1'b0;
      r_cout <= 1'b0;
      r_ov   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a   <= bus.a;
            r_b   <= (bus.select == OP_SUB) ? ~bus.b : bus.b;
            r_cy  <= bus.select;
            r_cnt <= '0;
          end
        end
        ST_RUN: begin
          r_out[r_cnt] <= w_sum;
          r_cy         <= w_cout;
          r_cnt        <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_cout;
            // Overflow uses the already-inverted B, so it covers add and sub.
            r_ov   <= (r_a[N_DIG-1][DIGIT_BITS-1] == r_b[N_DIG-1][DIGIT_BITS-1]) &&
                      (w_msb != r_a[N_DIG-1][DIGIT_BITS-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out       = r_out;
  assign bus.carry_out = r_cout;
  assign bus.overflow  = r_ov;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: directed table and corner sequences on the
// 32/8 configuration, plus random sweeps on 32/1, 32/32 and 4/2.
module tb_digit_serial_addsub;
  logic clk = 1'b0;
  logic rst_n;
  logic rst_sw_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   sweeps_done = 0;

  always #5 clk = ~clk;

  digit_serial_addsub_if #(.N_BITS(32)) bm ();
  digit_serial_addsub #(.N_BITS(32), .DIGIT_BITS(8)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(bm)
  );

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: {overflow, carry_out, out} from plain integer arithmetic.
  // Carry for subtract is "no borrow", i.e. a >= b unsigned.
  function automatic logic [65:0] ref_model(input int nb, input longint unsigned ua,
                                            input longint unsigned ub, input logic sel);
    longint unsigned m, ro;
    longint          sa, sb, sr, lim;
    logic            rc, rv;
    m   = (64'd1 << nb) - 64'd1;
    lim = longint'(64'd1 << (nb - 1));
    sa  = (ua >= 64'(lim)) ? longint'(ua) - 2 * lim : longint'(ua);
    sb  = (ub >= 64'(lim)) ? longint'(ub) - 2 * lim : longint'(ub);
    if (sel) begin
      ro = (ua - ub) & m;
      rc = (ua >= ub);
      sr = sa - sb;
    end else begin
      ro = (ua + ub) & m;
      rc = ((ua + ub) >> nb) != 0;
      sr = sa + sb;
    end
    rv = (sr > lim - 1) || (sr < -lim);
    return {rv, rc, ro};
  endfunction

  // One full operation on the main instance. Call at #1 after an edge, in IDLE.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                       output logic [65:0] res, output int lat);
    bm.a = ta; bm.b = tb_; bm.select = ts; bm.in_valid = 1'b1; bm.out_ready = 1'b1;
    @(posedge clk); #1;
    bm.in_valid = 1'b0;
    bm.a = $urandom; bm.b = $urandom; bm.select = ~ts;  // must not affect result
    lat = 0;
    while (!bm.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {bm.overflow, bm.carry_out, 32'd0, bm.out};
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [31:0] eo;
    logic        ec;
    logic        ev;
  } vec_t;

  // Random sweeps over other geometries, each with its own interface.
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int NB = (g == 2) ? 4 : 32;
    localparam int DB = (g == 0) ? 1 : (g == 1) ? 32 : 2;
    localparam int ND = NB / DB;

    digit_serial_addsub_if #(.N_BITS(NB)) sif ();
    digit_serial_addsub #(.N_BITS(NB), .DIGIT_BITS(DB)) u_dut (
      .clk(clk), .rst_n(rst_sw_n), .bus(sif)
    );

    initial begin
      logic [NB-1:0] ra, rb;
      logic          rs;
      logic [65:0]   exp, act;
      int            lat, stall;
      sif.a = '0; sif.b = '0; sif.select = 1'b0; sif.in_valid = 1'b0; sif.out_ready = 1'b0;
      wait (rst_sw_n === 1'b1);
      @(posedge clk); #1;
      for (int k = 0; k < 1000; k++) begin
        ra = NB'($urandom); rb = NB'($urandom); rs = 1'($urandom_range(0, 1));
        stall = $urandom_range(0, 2);
        sif.a = ra; sif.b = rb; sif.select = rs; sif.in_valid = 1'b1; sif.out_ready = 1'b0;
        @(posedge clk); #1;
        sif.in_valid = 1'b0; sif.a = NB'($urandom); sif.b = NB'($urandom);
        lat = 0;
        while (!sif.out_valid && lat < ND + 5) begin
          @(posedge clk); #1;
          lat++;
        end
        chk($sformatf("sw%0d latency op%0d", g, k), 66'(lat), 66'(ND));
        repeat (stall) begin @(posedge clk); #1; end
        exp = ref_model(NB, 64'(ra), 64'(rb), rs);
        act = {sif.overflow, sif.carry_out, 64'(sif.out)};
        chk($sformatf("sw%0d result op%0d a=%0h b=%0h sel=%0d", g, k, ra, rb, rs), act, exp);
        sif.out_ready = 1'b1;
        @(posedge clk); #1;
        sif.out_ready = 1'b0;
      end
      sweeps_done++;
    end
  end

  initial begin
    vec_t        vt[8];
    logic [65:0] res;
    int          lat, lo, hi, first;
    logic [31:0] ra, rb;
    logic        rs;

    vt[0] = '{32'd50,        32'd20,        1'b0, 32'd70,        1'b0, 1'b0};
    vt[1] = '{32'd3,         32'd2,         1'b1, 32'd1,         1'b1, 1'b0};
    vt[2] = '{32'd2,         32'd3,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vt[3] = '{32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[4] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         1'b1, 1'b0};
    vt[5] = '{32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[6] = '{32'd0,         32'd0,         1'b1, 32'd0,         1'b1, 1'b0};
    vt[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0,         1'b1, 1'b1};

    rst_n = 1'b0; rst_sw_n = 1'b0;
    bm.a = '0; bm.b = '0; bm.select = 1'b0; bm.in_valid = 1'b0; bm.out_ready = 1'b0;
    #1;
    chk("reset state", {31'd0, bm.in_ready, bm.out_valid, bm.carry_out, bm.overflow, bm.out},
        {31'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; rst_sw_n = 1'b1;

    // Handshake timing of a single add with the consumer always ready.
    bm.a = 32'd50; bm.b = 32'd20; bm.select = 1'b0; bm.in_valid = 1'b1; bm.out_ready = 1'b1;
    @(posedge clk); #1;
    bm.in_valid = 1'b0;
    lo = 0; hi = 0; first = -1; res = '0;
    for (int c = 0; c <= 8; c++) begin
      if (!bm.in_ready) lo++;
      if (bm.out_valid) begin
        hi++;
        if (first < 0) begin
          first = c;
          res = {bm.overflow, bm.carry_out, 32'd0, bm.out};
        end
      end
      @(posedge clk); #1;
    end
    chk("t1 out_valid rise", 66'(first), 66'd4);
    chk("t1 out_valid width", 66'(hi), 66'd1);
    chk("t1 in_ready low cycles", 66'(lo), 66'd5);
    chk("t1 result", res, {1'b0, 1'b0, 32'd0, 32'd70});

    // Directed table.
    foreach (vt[i]) begin
      do_op(vt[i].a, vt[i].b, vt[i].sel, res, lat);
      chk($sformatf("vec%0d latency", i), 66'(lat), 66'd4);
      chk($sformatf("vec%0d result", i), res, {vt[i].ev, vt[i].ec, 32'd0, vt[i].eo});
    end

    // Backpressure: result held, inputs ignored, no second accept.
    bm.a = 32'h1234; bm.b = 32'h5678; bm.select = 1'b0; bm.in_valid = 1'b1; bm.out_ready = 1'b0;
    @(posedge clk); #1;
    bm.in_valid = 1'b0;
    lat = 0;
    while (!bm.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp latency", 66'(lat), 66'd4);
    for (int c = 0; c < 6; c++) begin
      bm.a = $urandom; bm.b = $urandom; bm.select = 1'($urandom_range(0, 1));
      bm.in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk($sformatf("bp hold c%0d", c),
          {30'd0, bm.out_valid, bm.in_ready, bm.overflow, bm.carry_out, bm.out},
          {30'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h68AC});
    end
    bm.in_valid = 1'b0; bm.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release", {32'd0, bm.out_valid, bm.in_ready, bm.out},
        {32'd0, 1'b0, 1'b1, 32'h68AC});
    @(posedge clk); #1;
    chk("bp no second op", {32'd0, bm.out_valid, bm.in_ready, bm.out},
        {32'd0, 1'b0, 1'b1, 32'h68AC});

    // Asynchronous reset at count==2 discards the partial result.
    bm.a = 32'h1111_1111; bm.b = 32'h2222_2222; bm.select = 1'b0; bm.in_valid = 1'b1;
    @(posedge clk); #1;
    bm.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst partial digits", 66'(bm.out[15:0]), 66'h3333);
    rst_n = 1'b0;
    #1;
    chk("rst mid-run", {31'd0, bm.in_ready, bm.out_valid, bm.carry_out, bm.overflow, bm.out},
        {31'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(32'h5678, 32'h1234, 1'b1, res, lat);
    chk("post-rst latency", 66'(lat), 66'd4);
    chk("post-rst result", res, {1'b0, 1'b1, 32'd0, 32'h4444});

    // Random traffic on the main geometry.
    for (int k = 0; k < 200; k++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (k % 8 == 0) ra = {ra[31], 31'h7FFF_FFFF};
      do_op(ra, rb, rs, res, lat);
      chk($sformatf("main rnd%0d latency", k), 66'(lat), 66'd4);
      chk($sformatf("main rnd%0d a=%0h b=%0h sel=%0d", k, ra, rb, rs), res,
          ref_model(32, 64'(ra), 64'(rb), rs));
    end

    for (int t = 0; t < 90000 && sweeps_done < 3; t++) @(posedge clk);
    chk("sweeps completed", 66'(sweeps_done), 66'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
